// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encoding, flag layout and arbiter drain states.
package alu_pkg;

    typedef enum logic [3:0] {
        ADD  = 4'd0,
        SUB  = 4'd1,
        AND  = 4'd2,
        OR   = 4'd3,
        XOR  = 4'd4,
        SLL  = 4'd5,
        SRL  = 4'd6,
        SRA  = 4'd7,
        SLT  = 4'd8,
        SLTU = 4'd9
    } opcode_e;

    localparam int ALU_FLAGS_W = 4;
    // Bit positions inside the {overflow, carry, negative, zero} flag word
    localparam int FLAG_ZERO     = 0;
    localparam int FLAG_NEGATIVE = 1;
    localparam int FLAG_CARRY    = 2;
    localparam int FLAG_OVERFLOW = 3;

    typedef enum logic [1:0] {
        ARB_RUN     = 2'd0,
        ARB_DRAIN   = 2'd1,
        ARB_DRAINED = 2'd2
    } arb_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping.
module rr_arbiter #(
    parameter int N    = 4,
    parameter int ID_W = $clog2(N)
) (
    input  logic [N-1:0]    req,
    input  logic [ID_W-1:0] ptr,
    output logic [N-1:0]    grant,
    output logic [ID_W-1:0] grant_id,
    output logic            any
);

    int idx;

    // Walk the rotation from farthest to nearest so the nearest hit is kept.
    always_comb begin
        grant    = '0;
        grant_id = '0;
        any      = 1'b0;
        idx      = 0;
        for (int k = N - 1; k >= 0; k--) begin
            idx = (int'(ptr) + k) % N;
            if (req[idx]) begin
                grant      = '0;
                grant[idx] = 1'b1;
                grant_id   = ID_W'(idx);
                any        = 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_req_arbiter.sv
// Round-robin sharing of one fixed-latency ALU among N_REQ requesters, with
// owner tracking for responses and a drain FSM for quiescing.
module alu_req_arbiter
    import alu_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int N_REQ       = 4,
    parameter int ALU_LATENCY = 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [N_REQ-1:0]               req_valid,
    output logic [N_REQ-1:0]               req_ready,
    input  logic [N_REQ*WIDTH-1:0]         req_operand_a,
    input  logic [N_REQ*WIDTH-1:0]         req_operand_b,
    input  logic [N_REQ*$bits(opcode_e)-1:0] req_opcode,
    input  logic [N_REQ-1:0]               req_signed,
    input  logic                           hold,
    input  logic                           drain_req,
    output logic                           drain_done,
    output logic                           alu_valid,
    output logic [WIDTH-1:0]               alu_operand_a,
    output logic [WIDTH-1:0]               alu_operand_b,
    output opcode_e                        alu_opcode,
    output logic                           alu_signed_op,
    input  logic [WIDTH-1:0]               alu_result,
    input  logic [ALU_FLAGS_W-1:0]         alu_flags,
    output logic [N_REQ-1:0]               rsp_valid,
    output logic [WIDTH-1:0]               rsp_result,
    output logic [ALU_FLAGS_W-1:0]         rsp_flags,
    output logic [31:0]                    issue_count
);

    localparam int ID_W = $clog2(N_REQ);
    localparam int OP_W = $bits(opcode_e);

    arb_state_e             state_reg;
    logic [ID_W-1:0]        rr_ptr_reg;
    logic                   alu_valid_reg;
    logic [WIDTH-1:0]       alu_a_reg, alu_b_reg;
    opcode_e                alu_op_reg;
    logic                   alu_signed_reg;
    logic [ID_W-1:0]        alu_id_reg;
    logic                   tag_valid_reg [ALU_LATENCY];
    logic [ID_W-1:0]        tag_id_reg    [ALU_LATENCY];
    logic [3:0]             inflight_reg;
    logic [N_REQ-1:0]       rsp_valid_reg;
    logic [WIDTH-1:0]       rsp_result_reg;
    logic [ALU_FLAGS_W-1:0] rsp_flags_reg;
    logic                   drain_done_reg;
    logic [31:0]            issue_count_reg;

    logic [N_REQ-1:0]       grant;
    logic [ID_W-1:0]        grant_id;
    logic                   grant_any;
    logic                   grant_en;
    logic                   accept;
    logic                   tail_valid;
    logic [ID_W-1:0]        tail_id;

    rr_arbiter #(.N(N_REQ), .ID_W(ID_W)) u_rr (
        .req      (req_valid),
        .ptr      (rr_ptr_reg),
        .grant    (grant),
        .grant_id (grant_id),
        .any      (grant_any)
    );

    // drain_req gates grants in the same cycle it rises, before the FSM moves.
    assign grant_en   = (state_reg == ARB_RUN) && !hold && !drain_req;
    assign req_ready  = grant_en ? grant : '0;
    assign accept     = grant_en && grant_any;
    assign tail_valid = tag_valid_reg[ALU_LATENCY-1];
    assign tail_id    = tag_id_reg[ALU_LATENCY-1];

    // Tag stage 0 follows the issue register so the tail lines up with alu_result.
    for (genvar gi = 0; gi < ALU_LATENCY; gi++) begin : g_tag
        if (gi == 0) begin : g_head
            always_ff @(posedge clk) begin
                if (rst) begin
                    tag_valid_reg[gi] <= 1'b0;
                    tag_id_reg[gi]    <= '0;
                end else begin
                    tag_valid_reg[gi] <= alu_valid_reg;
                    tag_id_reg[gi]    <= alu_id_reg;
                end
            end
        end else begin : g_body
            always_ff @(posedge clk) begin
                if (rst) begin
                    tag_valid_reg[gi] <= 1'b0;
                    tag_id_reg[gi]    <= '0;
                end else begin
                    tag_valid_reg[gi] <= tag_valid_reg[gi-1];
                    tag_id_reg[gi]    <= tag_id_reg[gi-1];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= ARB_RUN;
            rr_ptr_reg      <= '0;
            alu_valid_reg   <= 1'b0;
            alu_a_reg       <= '0;
            alu_b_reg       <= '0;
            alu_op_reg      <= ADD;
            alu_signed_reg  <= 1'b0;
            alu_id_reg      <= '0;
            inflight_reg    <= '0;
            rsp_valid_reg   <= '0;
            rsp_result_reg  <= '0;
            rsp_flags_reg   <= '0;
            drain_done_reg  <= 1'b0;
            issue_count_reg <= '0;
        end else begin
            alu_valid_reg <= accept;
            if (accept) begin
                alu_a_reg       <= req_operand_a[int'(grant_id)*WIDTH +: WIDTH];
                alu_b_reg       <= req_operand_b[int'(grant_id)*WIDTH +: WIDTH];
                alu_op_reg      <= opcode_e'(req_opcode[int'(grant_id)*OP_W +: OP_W]);
                alu_signed_reg  <= req_signed[grant_id];
                alu_id_reg      <= grant_id;
                rr_ptr_reg      <= (grant_id == ID_W'(N_REQ - 1)) ? '0 : grant_id + 1'b1;
                issue_count_reg <= issue_count_reg + 32'd1;
            end

            rsp_valid_reg <= '0;
            if (tail_valid) begin
                rsp_valid_reg[tail_id] <= 1'b1;
                rsp_result_reg         <= alu_result;
                rsp_flags_reg          <= alu_flags;
            end

            // An op leaves the count when its result is captured for the response.
            if (accept && !tail_valid) begin
                inflight_reg <= inflight_reg + 4'd1;
            end else if (!accept && tail_valid) begin
                inflight_reg <= inflight_reg - 4'd1;
            end

            case (state_reg)
                ARB_RUN: begin
                    if (drain_req) begin
                        state_reg <= ARB_DRAIN;
                    end
                end
                ARB_DRAIN: begin
                    if (inflight_reg == 4'd0) begin
                        state_reg      <= ARB_DRAINED;
                        drain_done_reg <= 1'b1;
                    end
                end
                ARB_DRAINED: begin
                    if (!drain_req) begin
                        state_reg      <= ARB_RUN;
                        drain_done_reg <= 1'b0;
                    end
                end
                default: begin
                    state_reg      <= ARB_RUN;
                    drain_done_reg <= 1'b0;
                end
            endcase
        end
    end

    assign alu_valid     = alu_valid_reg;
    assign alu_operand_a = alu_a_reg;
    assign alu_operand_b = alu_b_reg;
    assign alu_opcode    = alu_op_reg;
    assign alu_signed_op = alu_signed_reg;
    assign rsp_valid     = rsp_valid_reg;
    assign rsp_result    = rsp_result_reg;
    assign rsp_flags     = rsp_flags_reg;
    assign drain_done    = drain_done_reg;
    assign issue_count   = issue_count_reg;

endmodule

// File: doc/alu_req_arbiter.md
Name: alu_req_arbiter

Overview:
Shares one ALU instance among N_REQ requesters (ALU front-end, stimulus masters, or future CPU-side ports). It arbitrates round-robin, registers the winning operation onto the ALU input bus, tracks each in-flight operation's owner through a fixed-latency tag pipeline, and returns the result only to the requester that issued it. A drain FSM lets the system quiesce the ALU, for example before reconfiguration or at end of test.

Parameters:
WIDTH, 32, operand/result width
N_REQ, 4, number of requesters (2..8)
ALU_LATENCY, 1, cycles from alu_valid to alu_result valid (1..4)
ID_W, $clog2(N_REQ), requester index width (derived, localparam)

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
req_valid  in  N_REQ  per-requester operation valid
req_ready  out  N_REQ  per-requester accept (combinational grant)
req_operand_a  in  N_REQ*WIDTH  packed operand A, requester i at [i*WIDTH +: WIDTH]
req_operand_b  in  N_REQ*WIDTH  packed operand B
req_opcode  in  N_REQ*$bits(opcode_e)  packed opcode_e
req_signed  in  N_REQ  signed_op per requester
hold  in  1  stall new grants; in-flight ops complete
drain_req  in  1  request quiesce
drain_done  out  1  high while drained and idle
alu_valid  out  1  registered issue strobe to ALU
alu_operand_a  out  WIDTH  registered
alu_operand_b  out  WIDTH  registered
alu_opcode  out  opcode_e  registered
alu_signed_op  out  1  registered
alu_result  in  WIDTH  ALU result, valid ALU_LATENCY cycles after alu_valid
alu_flags  in  4  {overflow, carry, negative, zero} from the ALU
rsp_valid  out  N_REQ  one-hot response strobe, single cycle, no backpressure
rsp_result  out  WIDTH  registered result, broadcast to all requesters
rsp_flags  out  4  registered flags, broadcast
issue_count  out  32  total accepted operations, wraps modulo 2^32

Behaviour:
- Reset (rst=1 at clk edge): all outputs 0, alu_opcode=ADD, rr pointer=0, tag pipe cleared, inflight=0, FSM=RUN. Reset mid-operation discards in-flight tags, and no rsp_valid fires for them.
- Grant is combinational. If FSM=RUN and hold=0, req_ready[i]=1 for exactly one i: the first requester with req_valid set, searching from rr_ptr upward with wrap. Otherwise req_ready=0. req_ready never asserts for a requester whose req_valid is low.
- Accept means req_valid[i] & req_ready[i]. On the next edge:
  - alu_* are loaded from requester i and alu_valid=1.
  - rr_ptr becomes (i+1) mod N_REQ.
  - issue_count increments.
- With no accept, alu_valid=0, alu_* hold their last value, and rr_ptr is unchanged.
- Throughput is one op per cycle; back-to-back grants to the same requester are allowed only when it is the sole one valid.
- Tag pipe: an ALU_LATENCY-deep shift register of {valid, id}, loaded with {1, i} alongside alu_valid. When the tail is valid, alu_result and alu_flags are registered into rsp_result and rsp_flags, and rsp_valid[id] is pulsed on the next edge.
- Latency: accept at cycle c, then alu_valid at c+1, then rsp_valid at c+2+ALU_LATENCY (c+3 at the default). Results return in issue order.
- inflight counter: +1 on accept, -1 on rsp_valid pulse, both in the same cycle gives net 0. Range 0..ALU_LATENCY+1.
- FSM:
  - RUN: drain_req=1 moves to DRAIN. Grants are blocked from that same cycle, because req_ready uses the current state and drain_req gates it combinationally.
  - DRAIN: no grants. When inflight==0, move to DRAINED.
  - DRAINED: drain_done=1. When drain_req=0, move to RUN and drain_done=0.
  - drain_req asserted with inflight already 0 reaches DRAINED after 2 edges (RUN, then DRAIN, then DRAINED).
- hold=1 and drain_req=1 together: drain proceeds normally.
- Requester deasserting req_valid without a handshake: legal, no side effects.

Decomposition:
- alu_pkg already holds opcode_e. Add to it:
  - ALU_FLAGS_W=4 and the flag bit index constants.
  - arb_state_e {ARB_RUN, ARB_DRAIN, ARB_DRAINED}.
- Sub-module rr_arbiter: parameter N, inputs req, ptr; outputs grant (one-hot), grant_id, any. Purely combinational, reusable.
- Tag pipe and FSM stay in alu_req_arbiter.

Test Plan:
- Single requester: req 2 valid with a=5, b=7, ADD, ALU_LATENCY=1 accepted at cycle c -> alu_valid at c+1 with operands 5/7, rsp_valid=4'b0100 at c+3, rsp_result=12, issue_count=1.
- All four requesters valid continuously, rr_ptr=0 -> grants in order 0,1,2,3,0,..., one per cycle; 8 responses arrive in the same order, each to the correct one-hot; max inflight equals 2 at ALU_LATENCY=1.
- Requester 1 alone valid for 3 cycles, then requester 0 joins -> grant order 1,1,1,0,1 (pointer wraps correctly).
- drain_req raised while 3 ops are in flight -> req_ready=0 immediately; all 3 rsp_valid pulses still occur; drain_done=1 on the cycle after inflight reaches 0; drain_req dropped -> grants resume next cycle.
- rst pulsed one cycle after two accepts -> no rsp_valid pulses afterwards, issue_count=0, FSM=RUN; a new op accepted afterwards completes normally.
- hold=1 with requester 3 valid for 5 cycles -> req_ready=0 and alu_valid=0 throughout; hold released -> requester 3 is granted on that cycle.
